// File: rtl/vz_image_loader.sv
// vz_image_loader: parses a .VZ snapshot from the HPS download port, streams the
// payload into system RAM through a small FIFO, then patches BASIC pointers or requests exec.
module vz_image_loader #(
  parameter logic [7:0] INDEX      = 8'd1,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        CLK42MHZ,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [7:0]  dn_index,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  file_type,
  output logic [15:0] exec_addr,
  output logic        exec_req
);
  localparam int          PW   = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FIX, S_DONE, S_ERR} state_t;
  state_t state;

  logic [15:0]   fifo_a [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt;
  logic [15:0]   start, data_len, end_addr;
  logic [4:0]    rx_cnt;
  logic [1:0]    fix_idx;
  logic          dl_q, inflight;
  logic          dl_rise, dl_fall, wr_ok, fifo_full, fifo_empty, push, pop;
  logic [7:0]    magic;

  assign dl_rise    = dn_download & ~dl_q;
  assign dl_fall    = ~dn_download & dl_q;
  assign wr_ok      = dn_wr && (dn_index == INDEX);
  assign fifo_full  = (cnt == FULL);
  assign fifo_empty = (cnt == '0);
  assign end_addr   = start + data_len;
  assign push       = (state == S_LOAD) && wr_ok && (dn_addr >= 16'd24) && !fifo_full;
  assign pop        = mem_we && mem_ack && (state != S_FIX);

  always_comb begin
    case (dn_addr[1:0])
      2'd0:    magic = 8'h56;
      2'd1:    magic = 8'h5A;
      2'd2:    magic = 8'h46;
      default: magic = 8'h30;
    endcase
  end

  // Write port: FIFO head while draining, fixup table in S_FIX, zero otherwise.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    case (state)
      S_LOAD, S_DRAIN: if (!fifo_empty) begin
        mem_we = 1'b1; mem_addr = fifo_a[rptr]; mem_wdata = fifo_d[rptr];
      end
      S_ERR: if (inflight) begin
        mem_we = 1'b1; mem_addr = fifo_a[rptr]; mem_wdata = fifo_d[rptr];
      end
      S_FIX: begin
        mem_we = 1'b1;
        case (fix_idx)
          2'd0:    begin mem_addr = 16'h78A4; mem_wdata = start[7:0];     end
          2'd1:    begin mem_addr = 16'h78A5; mem_wdata = start[15:8];    end
          2'd2:    begin mem_addr = 16'h78F9; mem_wdata = end_addr[7:0];  end
          default: begin mem_addr = 16'h78FA; mem_wdata = end_addr[15:8]; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK42MHZ) begin
    if (push) begin
      fifo_a[wptr] <= start + (dn_addr - 16'd24);
      fifo_d[wptr] <= dn_data;
    end
  end

  always_ff @(posedge CLK42MHZ or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      dl_q      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      start     <= '0;
      data_len  <= '0;
      rx_cnt    <= '0;
      fix_idx   <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      file_type <= 8'h00;
      exec_addr <= 16'h0000;
      exec_req  <= 1'b0;
    end else begin
      dl_q     <= dn_download;
      done     <= 1'b0;
      exec_req <= 1'b0;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      // Remember whether a write was left unacknowledged when entering ERROR.
      if (state != S_ERR) inflight <= mem_we && !mem_ack;
      else if (mem_ack)   inflight <= 1'b0;
      case (state)
        S_IDLE: if (dl_rise && dn_index == INDEX) begin
          state    <= S_LOAD;
          busy     <= 1'b1;
          err      <= 1'b0;
          err_code <= 2'd0;
          data_len <= '0;
          rx_cnt   <= '0;
          fix_idx  <= '0;
          wptr     <= '0;
          rptr     <= '0;
          cnt      <= '0;
        end
        S_LOAD: begin
          if (dl_fall) begin
            if (rx_cnt != 5'd24) begin state <= S_ERR; err <= 1'b1; err_code <= 2'd3; end
            else state <= S_DRAIN;
          end
          if (wr_ok) begin
            if (rx_cnt != 5'd24) rx_cnt <= rx_cnt + 1'b1;
            if (dn_addr < 16'd4) begin
              if (dn_data != magic) begin state <= S_ERR; err <= 1'b1; err_code <= 2'd1; end
            end else if (dn_addr == 16'd21) file_type   <= dn_data;
            else if (dn_addr == 16'd22)     start[7:0]  <= dn_data;
            else if (dn_addr == 16'd23)     start[15:8] <= dn_data;
            else if (dn_addr >= 16'd24) begin
              if (fifo_full) begin state <= S_ERR; err <= 1'b1; err_code <= 2'd2; end
              else data_len <= data_len + 1'b1;
            end
          end
        end
        S_DRAIN: if (fifo_empty) begin
          fix_idx <= '0;
          state   <= (file_type == 8'hF0) ? S_FIX : S_DONE;
        end
        S_FIX: if (mem_ack) begin
          fix_idx <= fix_idx + 1'b1;
          if (fix_idx == 2'd3) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (file_type == 8'hF1) begin exec_req <= 1'b1; exec_addr <= start; end
        end
        S_ERR: begin
          if (!inflight) begin rptr <= wptr; cnt <= '0; end
          if (!dn_download && fifo_empty && !inflight) begin state <= S_IDLE; busy <= 1'b0; end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
